// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame geometry and receiver FSM encoding.
// Imported by the receiver, its interface and the transmitter peer.
package uart_receiver_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receiver: 1-deep byte buffer with
// ready/ack handshake plus sticky error flags.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic                 rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rdy;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_ack,
        input  rx_data, rx_rdy, rx_busy, frame_err, overrun
    );

    modport slave (
        input  rx_ack,
        output rx_data, rx_rdy, rx_busy, frame_err, overrun
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous rxd pad.
// Resets to 1 so an idle line is never mistaken for a start edge.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a 1-deep byte buffer
// with sticky framing/overrun flags. All outputs are registered.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    uart_receiver_if.slave  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rxd_s;
    logic rxd_q;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_rdy_q, rx_rdy_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_rdy_d    = rx_rdy_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // Ack clears first so a coincident set event below takes priority.
        if (bus.rx_ack) begin
            rx_rdy_d    = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!rxd_s && rxd_q) state_d = START;
            end
            START: begin
                if (bit_cnt_q == CNT_HALF) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt_q == CNT_FULL) begin
                    bit_cnt_d = '0;
                    shreg_d   = {rxd_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) state_d = STOP;
                    else bit_idx_d = bit_idx_q + IW'(1);
                end
            end
            STOP: begin
                if (bit_cnt_q == CNT_FULL) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_rdy_q || bus.rx_ack) begin
                        rx_data_d = shreg_q;
                        rx_rdy_d  = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q       <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_q       <= rxd_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_rdy    = rx_rdy_q;
    assign bus.rx_busy   = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk/bit: framing, handshake,
// error flags, glitch rejection and mid-frame reset.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    int   n_pass = 0;
    int   n_total = 0;

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at a negedge with rxd left at stop value.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_rdy(input int max, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (bus.rx_rdy) ok = 1'b1;
        end
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        bus.rx_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if ({bus.rx_data, bus.rx_rdy, bus.rx_busy, bus.frame_err, bus.overrun}
            !== 12'h000)
            $display("FAIL reset_outputs got data=%h rdy=%b busy=%b fe=%b ov=%b want all 0",
                     bus.rx_data, bus.rx_rdy, bus.rx_busy, bus.frame_err, bus.overrun);
        else n_pass++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int cyc;
        fork
            send_byte(8'hA5, 1'b1);
            wait_rdy(400, ok, cyc);
        join
        n_total++;
        if (!ok || cyc < 153 || cyc > 158)
            $display("FAIL a5_latency got ok=%b cyc=%0d want 153..158", ok, cyc);
        else n_pass++;
        n_total++;
        if (bus.rx_data !== 8'hA5)
            $display("FAIL a5_data got %h want a5", bus.rx_data);
        else n_pass++;
        n_total++;
        if ({bus.frame_err, bus.overrun} !== 2'b00)
            $display("FAIL a5_flags got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun);
        else n_pass++;
        ack_pulse();
        n_total++;
        if (bus.rx_rdy !== 1'b0)
            $display("FAIL a5_ack got rdy=%b want 0", bus.rx_rdy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1;
        int c0, c1;
        logic [7:0] d0, d1;
        d0 = 8'hxx;
        d1 = 8'hxx;
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
            end
            begin
                wait_rdy(400, ok0, c0);
                d0 = bus.rx_data;
                ack_pulse();
                wait_rdy(400, ok1, c1);
                d1 = bus.rx_data;
                ack_pulse();
            end
        join
        n_total++;
        if (!ok0 || d0 !== 8'h00)
            $display("FAIL b2b_first got ok=%b data=%h want 1 00", ok0, d0);
        else n_pass++;
        n_total++;
        if (!ok1 || d1 !== 8'hFF)
            $display("FAIL b2b_second got ok=%b data=%h want 1 ff", ok1, d1);
        else n_pass++;
        n_total++;
        if ({bus.frame_err, bus.overrun} !== 2'b00)
            $display("FAIL b2b_flags got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        bit ok;
        int cyc;
        bit saw_activity;
        send_byte(8'h3C, 1'b0);
        n_total++;
        if ({bus.frame_err, bus.rx_rdy, bus.rx_data} !== {1'b1, 1'b0, 8'hFF})
            $display("FAIL ferr_set got fe=%b rdy=%b data=%h want 1 0 ff",
                     bus.frame_err, bus.rx_rdy, bus.rx_data);
        else n_pass++;
        saw_activity = 1'b0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (bus.rx_busy || bus.rx_rdy) saw_activity = 1'b1;
        end
        n_total++;
        if (saw_activity !== 1'b0)
            $display("FAIL break_no_frame got activity=%b want 0", saw_activity);
        else n_pass++;
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        fork
            send_byte(8'h11, 1'b1);
            wait_rdy(400, ok, cyc);
        join
        n_total++;
        if (!ok || bus.rx_data !== 8'h11)
            $display("FAIL after_break got ok=%b data=%h want 1 11", ok, bus.rx_data);
        else n_pass++;
        ack_pulse();
        n_total++;
        if ({bus.rx_rdy, bus.frame_err} !== 2'b00)
            $display("FAIL ferr_clear got rdy=%b fe=%b want 0 0", bus.rx_rdy, bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        int cyc;
        fork
            send_byte(8'h12, 1'b1);
            wait_rdy(400, ok, cyc);
        join
        send_byte(8'h34, 1'b1);
        n_total++;
        if ({ok, bus.rx_rdy, bus.rx_data, bus.overrun, bus.frame_err}
            !== {1'b1, 1'b1, 8'h12, 1'b1, 1'b0})
            $display("FAIL ovr_set got rdy=%b data=%h ov=%b fe=%b want 1 12 1 0",
                     bus.rx_rdy, bus.rx_data, bus.overrun, bus.frame_err);
        else n_pass++;
        ack_pulse();
        n_total++;
        if ({bus.rx_rdy, bus.overrun} !== 2'b00)
            $display("FAIL ovr_clear got rdy=%b ov=%b want 0 0", bus.rx_rdy, bus.overrun);
        else n_pass++;
        fork
            send_byte(8'h56, 1'b1);
            wait_rdy(400, ok, cyc);
        join
        n_total++;
        if (!ok || bus.rx_data !== 8'h56)
            $display("FAIL ovr_pre got ok=%b data=%h want 1 56", ok, bus.rx_data);
        else n_pass++;
        // Stop-bit decision for a frame started at N0 is taken at posedge 155.
        fork
            send_byte(8'h34, 1'b1);
            begin
                repeat (154) @(negedge clk);
                ack_pulse();
            end
        join
        n_total++;
        if ({bus.rx_rdy, bus.rx_data, bus.overrun} !== {1'b1, 8'h34, 1'b0})
            $display("FAIL ack_same_cycle got rdy=%b data=%h ov=%b want 1 34 0",
                     bus.rx_rdy, bus.rx_data, bus.overrun);
        else n_pass++;
        ack_pulse();
    endtask

    task automatic test_glitch();
        bit saw_busy;
        bit saw_out;
        saw_busy = 1'b0;
        saw_out = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rxd = 1'b1;
            @(negedge clk);
            if (bus.rx_busy) saw_busy = 1'b1;
            if (bus.rx_rdy || bus.frame_err || bus.overrun) saw_out = 1'b1;
        end
        n_total++;
        if (saw_busy !== 1'b1)
            $display("FAIL glitch_start got busy_seen=%b want 1", saw_busy);
        else n_pass++;
        n_total++;
        if ({saw_out, bus.rx_busy} !== 2'b00)
            $display("FAIL glitch_abort got out=%b busy=%b want 0 0", saw_out, bus.rx_busy);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int cyc;
        send_byte(8'h77, 1'b1);
        n_total++;
        if ({bus.rx_rdy, bus.rx_data} !== {1'b1, 8'h77})
            $display("FAIL pre_reset got rdy=%b data=%h want 1 77", bus.rx_rdy, bus.rx_data);
        else n_pass++;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (88) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_total++;
                if ({bus.rx_data, bus.rx_rdy, bus.rx_busy, bus.frame_err, bus.overrun}
                    !== 12'h000)
                    $display("FAIL mid_reset got data=%h rdy=%b busy=%b fe=%b ov=%b want all 0",
                             bus.rx_data, bus.rx_rdy, bus.rx_busy, bus.frame_err, bus.overrun);
                else n_pass++;
            end
        join
        rst = 1'b0;
        repeat (32) @(negedge clk);
        fork
            send_byte(8'hC3, 1'b1);
            wait_rdy(400, ok, cyc);
        join
        n_total++;
        if (!ok || bus.rx_data !== 8'hC3 || bus.frame_err !== 1'b0)
            $display("FAIL post_reset got ok=%b data=%h fe=%b want 1 c3 0",
                     ok, bus.rx_data, bus.frame_err);
        else n_pass++;
        ack_pulse();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
